// File: rtl/matrix_vec_loader.sv
// matrix_vec_loader: assembles a serial GF(2) frame (N x N matrix followed by
// an N-element vector) onto mat_o/vec_o for an external combinational
// multiplier. It then captures the returned product, checks it against an
// internally computed product, and holds the result under valid/ready
// handshaking.
module matrix_vec_loader #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic [N*N-1:0]   mat_o,
  output logic [N-1:0]     vec_o,
  input  logic [N-1:0]     u_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_u,
  output logic             out_err
);

  localparam int TOT = N*N + N;
  localparam int CW  = (TOT > 1) ? $clog2(TOT) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*N-1:0]  mat_q, mat_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [N-1:0]    out_u_q, out_u_d;
  logic            out_err_q, out_err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    prod;

  assign mat_o     = mat_q;
  assign vec_o     = vec_q;
  assign out_u     = out_u_q;
  assign out_err   = out_err_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // Reference GF(2) product of the held matrix and vector, used to audit u_i
  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i] = prod[i] ^ (mat_q[i*N+j] & vec_q[j]);
      end
    end
  end

  // Next-state logic: serial load, one evaluation cycle, then hold the result until consumed
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mat_d       = mat_q;
    vec_d       = vec_q;
    out_u_d     = out_u_q;
    out_err_d   = out_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N*N; k++) begin
            if (cnt_q == CW'(k)) mat_d[k] = in_bit;
          end
          for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(N*N + k)) vec_d[k] = in_bit;
          end
          if (cnt_q == CW'(TOT - 1)) begin
            cnt_d      = '0;
            state_d    = EVAL;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        // mat_o/vec_o have been stable for a full cycle, so u_i has settled
        out_u_d     = u_i;
        out_err_d   = (u_i != prod);
        state_d     = OUT;
        out_valid_d = 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          state_d     = LOAD;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = LOAD;
        cnt_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset returns to an empty LOAD with no pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      mat_q       <= '0;
      vec_q       <= '0;
      out_u_q     <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mat_q       <= mat_d;
      vec_q       <= vec_d;
      out_u_q     <= out_u_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/matrix_vec_loader.md
MATRIX_VEC_LOADER -- requirements
Module: matrix_vec_loader

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the matrix dimension (N x N binary matrix, N-element binary vector).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_bit carries a valid serial element.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts in_bit this cycle.
REQ-006 The block SHALL have port in_bit, input, 1 bit: serial element, GF(2).
REQ-007 The block SHALL have port mat_o, output, N*N bits: assembled matrix, with mat_o[i*N+j] = M[i][j], driven to the combinational multiplier.
REQ-008 The block SHALL have port vec_o, output, N bits: assembled vector, with vec_o[j] = v[j], driven to the multiplier.
REQ-009 The block SHALL have port u_i, input, N bits: product returned by the multiplier.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_u and out_err hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 The block SHALL have port out_u, output, N bits: registered product.
REQ-013 The block SHALL have port out_err, output, 1 bit: u_i disagreed with the internal GF(2) product.

Function
REQ-014 The block SHALL accept a bit when in_valid && in_ready at a rising clk edge.
REQ-015 Accepted bits SHALL be in the order M[0][0], M[0][1] .. M[0][N-1], M[1][0] .. M[N-1][N-1], then v[0] .. v[N-1], for N*N+N bits per frame.
REQ-016 Each accepted bit SHALL be written immediately to its mat_o/vec_o position; all other positions SHALL hold their values.
REQ-017 An element counter of width clog2(N*N+N) SHALL index the frame, running 0 .. N*N+N-1, and SHALL return to 0 at frame end (no wrap within a frame).
REQ-018 The FSM SHALL have three states:
- LOAD: in_ready=1, out_valid=0.
- EVAL: in_ready=0, out_valid=0.
- OUT: in_ready=0, out_valid=1.
REQ-019 The FSM SHALL make these transitions:
- LOAD -> EVAL on acceptance of bit index N*N+N-1.
- EVAL -> OUT unconditionally after one cycle.
- OUT -> LOAD when out_ready=1 (counter is 0).
REQ-020 In LOAD, cycles with in_valid=0 SHALL leave all state unchanged.
REQ-021 On the EVAL->OUT edge, the block SHALL register out_u <= u_i and out_err <= (u_i != p), where p[i] = XOR over j of (M[i][j] AND v[j]), computed internally from mat_o/vec_o.
REQ-022 Latency SHALL be as follows: out_valid=1 exactly one clk edge after the edge that accepted the final vector bit.
REQ-023 mat_o and vec_o SHALL remain stable throughout EVAL and OUT.
REQ-024 out_u and out_err SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-025 out_valid SHALL deassert on the edge on which out_ready=1 is sampled in OUT, and in_ready SHALL assert in the same cycle.
- A new frame's first bit is accepted no earlier than the following edge.
REQ-026 out_ready SHALL be ignored outside OUT.
REQ-027 in_valid and in_bit SHALL be ignored outside LOAD.
REQ-028 out_u and out_err SHALL retain the last result after OUT until the next capture.

Reset
REQ-029 While rst_n=0, regardless of clk, the block SHALL be in state LOAD with counter=0, mat_o=0, vec_o=0, out_u=0, out_err=0, out_valid=0, and in_ready=1.
REQ-030 Reset asserted mid-frame or in OUT SHALL discard the partial frame or pending result with no output pulse.
REQ-031 After rst_n rises, the first accepted bit SHALL be M[0][0].

Verification
REQ-032 Zero frame (N=3): 12 zero bits, u_i driven by a real multiplier -> out_u=000, out_err=0, out_valid high one edge after bit 11 is accepted.
REQ-033 Identity frame: M=I (mat_o=9'b100010001), v=101 (vec_o=3'b101) -> out_u=101, out_err=0.
REQ-034 Backpressure: all-ones M, v=111, out_ready held 0 for 5 cycles -> out_u=111 stable, in_ready=0, then a single out_ready pulse -> out_valid=0 and in_ready=1 next cycle.
REQ-035 Reset mid-load: after 5 bits accepted, pulse rst_n low between clk edges -> immediate mat_o=0, counter=0; the next 12-bit frame loads correctly.
REQ-036 Mismatch: u_i forced to 000 with M=I and v=001 -> out_u=000, out_err=1.
REQ-037 Gapped input: in_valid toggled randomly over a 12-bit frame -> the result is identical to the same frame sent gap-free.
